uart_frame_encoder: RTL

// Parametrised UART frame builder for the blackjack link. It sits between the game/dealer

---
 rtl/uart_frame_encoder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_encoder.sv
// uart_frame_encoder
//   Builds one UART frame from a snapshot of the blackjack game status and
//   NUM_CARDS card values, then writes it byte by byte into the UART TX FIFO.
//   Frame: header {00,deal,dealer_finished,tag 0}, one byte per card
//   {card,tag i}, then a checksum byte {xor of all payload nibbles, tag F}.
//   A frame starts on send_req, on a request merged while busy (pending), or,
//   with AUTO_SEND, whenever the live inputs differ from the last frame sent.
//   Legal NUM_CARDS range is 1..14 so every tag fits in four bits and never
//   collides with the checksum tag.
//
// Ports
//   clk             system clock
//   rst             synchronous reset, active low
//   tx_full         TX FIFO full; no write is issued while high
//   send_req        frame request (pulse or level)
//   deal            status bit carried in the header
//   dealer_finished status bit carried in the header
//   card_values     card i at [4*i+3:4*i]
//   wr_uart         one-cycle FIFO write strobe
//   w_data          byte written, valid while wr_uart is high
//   busy            frame in progress
//   frame_done      one-cycle pulse after the last byte has been written
module uart_frame_encoder #(
  parameter int unsigned NUM_CARDS  = 4,
  parameter bit          AUTO_SEND  = 1'b1,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tx_full,
  input  logic                   send_req,
  input  logic                   deal,
  input  logic                   dealer_finished,
  input  logic [4*NUM_CARDS-1:0] card_values,
  output logic                   wr_uart,
  output logic [7:0]             w_data,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int unsigned CARD_W = 4 * NUM_CARDS;
  localparam int unsigned SNAP_W = CARD_W + 2;
  localparam int unsigned IDX_W  = $clog2(NUM_CARDS + 2);
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CARDS + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [SNAP_W-1:0] snap_q, snap_d;
  logic [SNAP_W-1:0] last_q, last_d;
  logic              sent_valid_q, sent_valid_d;
  logic              pending_q, pending_d;
  logic              wr_uart_q, wr_uart_d;
  logic [7:0]        w_data_q, w_data_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;

  logic [SNAP_W-1:0] cur_snap;
  logic              auto_trig;
  logic              trigger;
  logic [3:0]        chk;
  logic [7:0]        tx_byte;

  // Snapshot layout: {deal, dealer_finished, card_values}
  always_comb begin
    cur_snap  = {deal, dealer_finished, card_values};
    auto_trig = AUTO_SEND && (!sent_valid_q || (cur_snap != last_q));
    trigger   = send_req || pending_q || auto_trig;
  end

  // Byte selected by idx, always built from the latched snapshot
  always_comb begin
    chk = {2'b00, snap_q[SNAP_W-1], snap_q[SNAP_W-2]};
    for (int i = 0; i < int'(NUM_CARDS); i++) begin
      chk = chk ^ snap_q[4*i +: 4];
    end
    tx_byte = {chk, 4'hF};
    if (idx_q == '0) begin
      tx_byte = {2'b00, snap_q[SNAP_W-1], snap_q[SNAP_W-2], 4'h0};
    end
    for (int i = 0; i < int'(NUM_CARDS); i++) begin
      if (idx_q == IDX_W'(i + 1)) begin
        tx_byte = {snap_q[4*i +: 4], 4'(i + 1)};
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    snap_d       = snap_q;
    last_d       = last_q;
    sent_valid_d = sent_valid_q;
    pending_d    = pending_q;
    wr_uart_d    = 1'b0;
    w_data_d     = w_data_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    // Requests arriving while a frame is in flight merge into one follow-up
    if (send_req && (state_q != S_IDLE)) begin
      pending_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          snap_d    = cur_snap;
          idx_d     = '0;
          pending_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_full) begin
          wr_uart_d = 1'b1;
          w_data_d  = tx_byte;
          gap_d     = '0;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        // The strobe occupies the first gap cycle
        if (gap_q == GAP_LAST) begin
          if (idx_q == IDX_LAST) begin
            frame_done_d = 1'b1;
            state_d      = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_SEND;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_DONE: begin
        last_d       = snap_q;
        sent_valid_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      gap_q        <= '0;
      snap_q       <= '0;
      last_q       <= '0;
      sent_valid_q <= 1'b0;
      pending_q    <= 1'b0;
      wr_uart_q    <= 1'b0;
      w_data_q     <= 8'h00;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      snap_q       <= snap_d;
      last_q       <= last_d;
      sent_valid_q <= sent_valid_d;
      pending_q    <= pending_d;
      wr_uart_q    <= wr_uart_d;
      w_data_q     <= w_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_uart    = wr_uart_q;
  assign w_data     = w_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
